// File: rtl/ball_wall_collision_unit_pkg.sv
// rtl/ball_wall_collision_unit_pkg.sv - shared defaults, FSM states and wall limits for the wall collision unit
// Purpose: playfield/ball default geometry, the FSM state encoding and the
//   wall limit helpers shared by the collision unit and its bench-facing top.
// Ports: none (package).
package ball_wall_collision_unit_pkg;

  localparam int COORD_W_DEF   = 16;
  localparam int SCREEN_W_DEF  = 640;
  localparam int SCREEN_H_DEF  = 480;
  localparam int BALL_SIZE_DEF = 10;
  localparam int CNT_W_DEF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  localparam int TOP_LIM  = 0;
  localparam int LEFT_LIM = 0;

  function automatic int bot_lim(input int screen_h, input int ball_size);
    return screen_h - ball_size;
  endfunction

  function automatic int right_lim(input int screen_w, input int ball_size);
    return screen_w - ball_size;
  endfunction

endpackage

// File: rtl/ball_wall_collision_unit_vel_sat_negate.sv
// rtl/ball_wall_collision_unit_vel_sat_negate.sv - saturating two's complement negator
// Purpose: dout = -din, except the most negative value maps to the most positive.
// Ports:
//   din   in  W  signed input word
//   dout  out W  saturated negation of din
module ball_wall_collision_unit_vel_sat_negate #(
  parameter int W = 16
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  // ~MOST_NEG is the most positive value, so saturation is a plain inversion.
  always_comb begin
    dout = (din == MOST_NEG) ? ~din : (~din + W'(1));
  end

endmodule

// File: rtl/ball_wall_collision_unit.sv
// rtl/ball_wall_collision_unit.sv - frame-synchronous ball/wall collision engine
// Purpose: on each frame_tick, checks the ball box against all four screen
//   edges; top/bottom hits reflect vy and clamp y, left/right raise score pulses.
//   Optional SERVE_RESET_EN: a score re-centres the ball, negates vx and
//   clears bounce_cnt.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   frame_tick                      start pulse, latches ball_* in IDLE
//   clr_cnt                         synchronous clear of bounce_cnt (wins over bounce)
//   ball_x/y, ball_vx/vy            signed position and velocity in
//   busy                            high while not IDLE
//   done                            1-cycle pulse, result outputs valid
//   x_out, y_out, vx_out, vy_out    corrected position and velocity
//   hit_top, hit_bottom             vertical bounce pulses (with done)
//   score_left, score_right         score pulses (with done)
//   bounce_cnt                      saturating vertical bounce count
//   overrun                         sticky: frame_tick seen while busy
module ball_wall_collision_unit
  import ball_wall_collision_unit_pkg::*;
#(
  parameter int COORD_W   = COORD_W_DEF,
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int BALL_SIZE = BALL_SIZE_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               clr_cnt,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] ball_vx,
  input  logic [COORD_W-1:0] ball_vy,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic [COORD_W-1:0] vx_out,
  output logic [COORD_W-1:0] vy_out,
  output logic               hit_top,
  output logic               hit_bottom,
  output logic               score_left,
  output logic               score_right,
  output logic [CNT_W-1:0]   bounce_cnt,
  output logic               overrun
);

  localparam logic signed [COORD_W-1:0] ZERO    = '0;
  localparam logic signed [COORD_W-1:0] TOP_L   = COORD_W'(TOP_LIM);
  localparam logic signed [COORD_W-1:0] LEFT_L  = COORD_W'(LEFT_LIM);
  localparam logic signed [COORD_W-1:0] BOT_L   = COORD_W'(bot_lim(SCREEN_H, BALL_SIZE));
  localparam logic signed [COORD_W-1:0] RIGHT_L = COORD_W'(right_lim(SCREEN_W, BALL_SIZE));

  state_e state_q, state_d;
  logic signed [COORD_W-1:0] x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
  logic top_q, top_d, bot_q, bot_d, sl_q, sl_d, sr_q, sr_d;
  logic [COORD_W-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
  logic [COORD_W-1:0] vx_out_q, vx_out_d, vy_out_q, vy_out_d;
  logic done_q, done_d, hit_top_q, hit_top_d, hit_bottom_q, hit_bottom_d;
  logic score_left_q, score_left_d, score_right_q, score_right_d;
  logic [CNT_W-1:0] bounce_cnt_q, bounce_cnt_d;
  logic overrun_q, overrun_d;
  logic [COORD_W-1:0] vy_neg;

  ball_wall_collision_unit_vel_sat_negate #(.W(COORD_W)) u_vy_neg (
    .din  (vy_q),
    .dout (vy_neg)
  );

`ifdef SERVE_RESET_EN
  localparam logic [COORD_W-1:0] SERVE_X = COORD_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] SERVE_Y = COORD_W'((SCREEN_H - BALL_SIZE) / 2);
  logic [COORD_W-1:0] vx_neg;

  ball_wall_collision_unit_vel_sat_negate #(.W(COORD_W)) u_vx_neg (
    .din  (vx_q),
    .dout (vx_neg)
  );
`endif

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    vx_d           = vx_q;
    vy_d           = vy_q;
    top_d          = top_q;
    bot_d          = bot_q;
    sl_d           = sl_q;
    sr_d           = sr_q;
    x_out_d        = x_out_q;
    y_out_d        = y_out_q;
    vx_out_d       = vx_out_q;
    vy_out_d       = vy_out_q;
    bounce_cnt_d   = bounce_cnt_q;
    done_d         = 1'b0;
    hit_top_d      = 1'b0;
    hit_bottom_d   = 1'b0;
    score_left_d   = 1'b0;
    score_right_d  = 1'b0;
    overrun_d      = overrun_q | (frame_tick && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          x_d     = ball_x;
          y_d     = ball_y;
          vx_d    = ball_vx;
          vy_d    = ball_vy;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        // The vy sign terms make top and bottom mutually exclusive.
        top_d   = (y_q <= TOP_L) && (vy_q < ZERO);
        bot_d   = (y_q >= BOT_L) && (vy_q > ZERO);
        sr_d    = (x_q <= LEFT_L);
        sl_d    = (x_q >= RIGHT_L);
        state_d = ST_APPLY;
      end
      ST_APPLY: begin
        x_out_d       = x_q;
        vx_out_d      = vx_q;
        vy_out_d      = (top_q || bot_q) ? vy_neg : vy_q;
        y_out_d       = top_q ? TOP_L : (bot_q ? BOT_L : y_q);
        done_d        = 1'b1;
        hit_top_d     = top_q;
        hit_bottom_d  = bot_q;
        score_left_d  = sl_q;
        score_right_d = sr_q;
        if ((top_q || bot_q) && (bounce_cnt_q != '1)) begin
          bounce_cnt_d = bounce_cnt_q + CNT_W'(1);
        end
`ifdef SERVE_RESET_EN
        if (sl_q || sr_q) begin
          x_out_d      = SERVE_X;
          y_out_d      = SERVE_Y;
          vx_out_d     = vx_neg;
          bounce_cnt_d = '0;
        end
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (clr_cnt) begin
      bounce_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      vx_q          <= '0;
      vy_q          <= '0;
      top_q         <= 1'b0;
      bot_q         <= 1'b0;
      sl_q          <= 1'b0;
      sr_q          <= 1'b0;
      x_out_q       <= '0;
      y_out_q       <= '0;
      vx_out_q      <= '0;
      vy_out_q      <= '0;
      done_q        <= 1'b0;
      hit_top_q     <= 1'b0;
      hit_bottom_q  <= 1'b0;
      score_left_q  <= 1'b0;
      score_right_q <= 1'b0;
      bounce_cnt_q  <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      vx_q          <= vx_d;
      vy_q          <= vy_d;
      top_q         <= top_d;
      bot_q         <= bot_d;
      sl_q          <= sl_d;
      sr_q          <= sr_d;
      x_out_q       <= x_out_d;
      y_out_q       <= y_out_d;
      vx_out_q      <= vx_out_d;
      vy_out_q      <= vy_out_d;
      done_q        <= done_d;
      hit_top_q     <= hit_top_d;
      hit_bottom_q  <= hit_bottom_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      bounce_cnt_q  <= bounce_cnt_d;
      overrun_q     <= overrun_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign x_out       = x_out_q;
  assign y_out       = y_out_q;
  assign vx_out      = vx_out_q;
  assign vy_out      = vy_out_q;
  assign hit_top     = hit_top_q;
  assign hit_bottom  = hit_bottom_q;
  assign score_left  = score_left_q;
  assign score_right = score_right_q;
  assign bounce_cnt  = bounce_cnt_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_ball_wall_collision_unit.sv
// tb/tb_ball_wall_collision_unit.sv - self-checking bench for the wall collision unit
module tb_ball_wall_collision_unit;

  logic        clk = 1'b0;
  logic        rst_n, frame_tick, clr_cnt;
  logic [15:0] ball_x, ball_y, ball_vx, ball_vy;
  logic        busy, done, hit_top, hit_bottom, score_left, score_right, overrun;
  logic [15:0] x_out, y_out, vx_out, vy_out;
  logic [7:0]  bounce_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt    = 0;

  ball_wall_collision_unit dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .clr_cnt(clr_cnt),
    .ball_x(ball_x), .ball_y(ball_y), .ball_vx(ball_vx), .ball_vy(ball_vy),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out),
    .vx_out(vx_out), .vy_out(vy_out), .hit_top(hit_top), .hit_bottom(hit_bottom),
    .score_left(score_left), .score_right(score_right),
    .bounce_cnt(bounce_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] w16(input int v);
    return v[15:0];
  endfunction

  function automatic int sneg(input int v);
    return (v == -32768) ? 32767 : -v;
  endfunction

  function automatic int rnd_s16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  // Model: ball box against the 640x480 field with a 10-pixel ball.
  task automatic frame(input int x, input int y, input int vx, input int vy, input bit clr);
    bit t, b, sl, sr;
    int ex, ey, evx, evy;
    t   = (y <= 0) && (vy < 0);
    b   = (y >= 470) && (vy > 0);
    sr  = (x <= 0);
    sl  = (x >= 630);
    ex  = x;
    evx = vx;
    ey  = t ? 0 : (b ? 470 : y);
    evy = (t || b) ? sneg(vy) : vy;
    if ((t || b) && m_cnt < 255) m_cnt++;
`ifdef SERVE_RESET_EN
    if (sl || sr) begin
      ex = 315; ey = 235; evx = sneg(vx); m_cnt = 0;
    end
`endif
    if (clr) m_cnt = 0;

    @(negedge clk);
    ball_x = w16(x); ball_y = w16(y); ball_vx = w16(vx); ball_vy = w16(vy);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    chk("busy", busy, 1);
    @(negedge clk);
    frame_tick = 1'b0;
    ball_x = 16'($urandom); ball_y = 16'($urandom);
    ball_vx = 16'($urandom); ball_vy = 16'($urandom);
    @(posedge clk); #1;
    chk("done_early", done, 0);
    @(negedge clk);
    clr_cnt = clr;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("done", done, 1);
    chk("x_out", x_out, w16(ex));
    chk("y_out", y_out, w16(ey));
    chk("vx_out", vx_out, w16(evx));
    chk("vy_out", vy_out, w16(evy));
    chk("hit_top", hit_top, t);
    chk("hit_bottom", hit_bottom, b);
    chk("score_left", score_left, sl);
    chk("score_right", score_right, sr);
    chk("bounce_cnt", bounce_cnt, m_cnt);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("hit_pulse", hit_top | hit_bottom | score_left | score_right, 0);
    chk("hold_y", y_out, w16(ey));
    chk("idle", busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pos"}, {x_out, y_out}, 0);
    chk({tag, "_vel"}, {vx_out, vy_out}, 0);
    chk({tag, "_pulses"}, {hit_top, hit_bottom, score_left, score_right}, 0);
    chk({tag, "_cnt"}, bounce_cnt, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int ndone;
    int rx, ry;
    rst_n = 1'b0; frame_tick = 1'b0; clr_cnt = 1'b0;
    ball_x = '0; ball_y = '0; ball_vx = '0; ball_vy = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    frame(300, -3, 4, -5, 0);
    frame(300, 475, 0, 6, 0);
    frame(300, 475, 0, -6, 0);
    frame(-2, 100, -7, 2, 0);
    frame(635, 0, 3, -1, 0);
    frame(300, 475, 0, 32767, 0);
    frame(0, 470, 1, 0, 0);

    // Second tick while busy: ignored, overrun set, exactly one done.
    @(negedge clk);
    ball_x = 16'd300; ball_y = 16'd200; ball_vx = 16'd1; ball_vy = 16'd1;
    frame_tick = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("overrun", overrun, 1);
    chk("one_done", ndone, 1);
    chk("ovr_cnt", bounce_cnt, m_cnt);

    // Reset during EVAL aborts the frame.
    @(negedge clk);
    ball_x = 16'd300; ball_y = 16'hFFFD; ball_vx = 16'd4; ball_vy = 16'hFFFB;
    frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    m_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    for (int i = 0; i < 260; i++) frame(300, 475, 0, 6, 0);
    chk("sat_cnt", bounce_cnt, 255);
    frame(300, 475, 0, 6, 1);

    for (int i = 0; i < 200; i++) begin
      rx = ($urandom_range(0, 3) == 0) ? rnd_s16() : int'($urandom_range(0, 680)) - 20;
      ry = ($urandom_range(0, 3) == 0) ? rnd_s16() : int'($urandom_range(0, 520)) - 20;
      frame(rx, ry,
            ($urandom_range(0, 7) == 0) ? rnd_s16() : int'($urandom_range(0, 20)) - 10,
            ($urandom_range(0, 7) == 0) ? rnd_s16() : int'($urandom_range(0, 20)) - 10,
            $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
